// File: rtl/mdr_mem_port.sv
// ============================================================================
// Module      : mdr_mem_port
// Description : MAR/MDR capture from BusMuxOut plus a req/ack port to external
//               memory. Optional request timeout when MEM_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdr_mem_port #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 9,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mar_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } stateT;

  stateT             r_state;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic              r_memWe;
  logic              r_done;
  logic              w_start;
  logic              w_expire;

  assign w_start = Read | Write;

`ifdef MEM_TIMEOUT_EN
  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES);

  logic [TIMER_W-1:0] r_timer;
  logic               r_err;

  // Expiry is the last unacknowledged REQ cycle; an ack in that cycle wins.
  assign w_expire = (r_state == REQ) && !mem_ack && (r_timer == TIMER_W'(1));

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_timer <= '0;
      r_err   <= 1'b0;
    end else if (r_state == IDLE && w_start) begin
      r_timer <= TIMER_LOAD;
      r_err   <= 1'b0;
    end else if (r_state == REQ && !mem_ack) begin
      r_timer <= r_timer - TIMER_W'(1);
      if (w_expire) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic [31:0] w_unusedTimeout;

  assign w_unusedTimeout = 32'(TIMEOUT_CYCLES);
  assign w_expire        = 1'b0;
  assign err             = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state    <= IDLE;
      r_mar      <= '0;
      r_mdr      <= '0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_memWe    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // A start takes priority over register loads in the same cycle.
          if (Read) begin
            r_memAddr <= r_mar;
            r_memWe   <= 1'b0;
            r_state   <= REQ;
          end else if (Write) begin
            r_memAddr  <= r_mar;
            r_memWdata <= r_mdr;
            r_memWe    <= 1'b1;
            r_state    <= REQ;
          end else begin
            if (MARin) begin
              r_mar <= bus_in[ADDR_W-1:0];
            end
            if (MDRin) begin
              r_mdr <= bus_in;
            end
          end
        end
        REQ: begin
          if (mem_ack || w_expire) begin
            if (mem_ack && !r_memWe) begin
              r_mdr <= mem_rdata;
            end
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mdr_out   = r_mdr;
  assign mar_out   = r_mar;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign mem_we    = r_memWe;
  assign mem_req   = (r_state == REQ);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mdr_mem_port.sv
// ============================================================================
// Module      : tb_mdr_mem_port
// Description : Scoreboard bench for mdr_mem_port with a transaction-level
//               reference model and a randomized memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdr_mem_port;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          clear_n;
  logic [DW-1:0] bus_in;
  logic          MARin, MDRin, Read, Write;
  logic [DW-1:0] mdr_out, mem_wdata, mem_rdata;
  logic [AW-1:0] mar_out, mem_addr;
  logic          mem_we, mem_req, mem_ack, busy, done, err;

  mdr_mem_port #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .clear_n(clear_n), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .mdr_out(mdr_out), .mar_out(mar_out), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } reqT;

  reqT           reqQ[$];
  logic [DW-1:0] doneQ[$];
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [AW-1:0] mMar;
  logic [DW-1:0] mMdr;
  logic          mPend, mWe, mDone, mErr;
  int            mAge;

  always @(posedge clock) begin
    reqT e;
    if (!clear_n) begin
      mMar = '0; mMdr = '0; mPend = 1'b0; mWe = 1'b0; mDone = 1'b0; mErr = 1'b0; mAge = 0;
    end else begin
      mDone = 1'b0;
      if (!mPend) begin
        if (Read || Write) begin
          e.we = !Read; e.addr = mMar; e.wdata = mMdr;
          reqQ.push_back(e);
          mPend = 1'b1; mWe = e.we; mAge = 0; mErr = 1'b0;
        end else begin
          if (MARin) mMar = bus_in[AW-1:0];
          if (MDRin) mMdr = bus_in;
        end
      end else begin
        mAge++;
        if (mem_ack) begin
          if (!mWe) mMdr = mem_rdata;
          mPend = 1'b0; mDone = 1'b1; doneQ.push_back(mMdr);
        end
`ifdef MEM_TIMEOUT_EN
        else if (mAge == TO) begin
          mErr = 1'b1; mPend = 1'b0; mDone = 1'b1; doneQ.push_back(mMdr);
        end
`endif
      end
    end
  end

  // ---------------- memory responder ----------------
  bit            randMode = 1'b0;
  bit            forceAck = 1'b0;
  int            ackAfter = 1;
  logic [DW-1:0] rdataNext = '0;
  int            reqCyc = 0;
  int            lim = 1;

  always @(negedge clock) begin
    mem_ack = 1'b0;
    if (clear_n !== 1'b1) begin
      reqCyc = 0;
    end else if (mem_req === 1'b1) begin
      reqCyc++;
      if (reqCyc == 1) begin
`ifdef MEM_TIMEOUT_EN
        lim = randMode ? int'($urandom_range(1, 6)) : ackAfter;
`else
        lim = randMode ? int'($urandom_range(1, 4)) : ackAfter;
`endif
      end
      if (reqCyc == lim) begin
        mem_ack   = 1'b1;
        mem_rdata = randMode ? $urandom : rdataNext;
      end
    end else begin
      reqCyc = 0;
      if (forceAck || (randMode && $urandom_range(0, 7) == 0)) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit            started = 1'b0;
  logic          prevReq = 1'b0;
  reqT           cur;
  int            curLen = 0, lastLen = 0, reqCount = 0, doneCount = 0;
  logic          lastWe;
  logic [AW-1:0] lastAddr;
  logic [DW-1:0] lastWdata;

  always @(negedge clock) begin
    if (started) begin
      chk("mar_out", 32'(mar_out), 32'(mMar));
      chk("mdr_out", mdr_out, mMdr);
      chk("mem_req", 32'(mem_req), 32'(mPend));
      chk("busy",    32'(busy),    32'(mPend));
      chk("done",    32'(done),    32'(mDone));
      chk("err",     32'(err),     32'(mErr));
      if (mem_req === 1'b1 && !prevReq) begin
        reqCount++; curLen = 0;
        lastWe = mem_we; lastAddr = mem_addr; lastWdata = mem_wdata;
        checks++;
        if (reqQ.size() == 0) begin
          failures++;
          $display("FAIL req_unexpected actual=request expected=none");
          cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
        end else begin
          cur = reqQ.pop_front();
        end
      end
      if (mem_req === 1'b1) begin
        curLen++;
        chk("req_we",   32'(mem_we),   32'(cur.we));
        chk("req_addr", 32'(mem_addr), 32'(cur.addr));
        if (cur.we) chk("req_wdata", mem_wdata, cur.wdata);
      end else if (prevReq) begin
        lastLen = curLen;
      end
      if (done === 1'b1) begin
        doneCount++;
        checks++;
        if (doneQ.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected actual=pulse expected=none");
        end else begin
          chk("done_mdr", mdr_out, doneQ.pop_front());
        end
      end
      prevReq = (mem_req === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic w, input logic ma, input logic md,
                       input logic [DW-1:0] b);
    Read = r; Write = w; MARin = ma; MDRin = md; bus_in = b;
    @(negedge clock);
    Read = 1'b0; Write = 1'b0; MARin = 1'b0; MDRin = 1'b0; bus_in = '0;
  endtask

  task automatic waitDone(input string nm);
    int k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk(nm, 32'(k < 40), 32'd1);
    @(negedge clock);
  endtask

  int rc0, dc0;

  initial begin
    clear_n = 1'b0; bus_in = '0; MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clock);
    started = 1'b1;
    chk("rst_mar", 32'(mar_out), 32'd0);
    chk("rst_mdr", mdr_out, 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    clear_n = 1'b1;
    @(negedge clock);

    // 1: register loads with address truncation
    drive(0, 0, 1, 0, 32'h0000_0A05);
    drive(0, 0, 0, 1, 32'h1234_5678);
    chk("t1_mar", 32'(mar_out), 32'h005);
    chk("t1_mdr", mdr_out, 32'h1234_5678);

    // 2: read with ack in the third request cycle
    drive(0, 0, 1, 0, 32'h10);
    ackAfter = 3; rdataNext = 32'hCAFE_F00D; dc0 = doneCount;
    drive(1, 0, 0, 0, 32'h0);
    waitDone("t2_done_wait");
    repeat (2) @(negedge clock);
    chk("t2_mdr", mdr_out, 32'hCAFE_F00D);
    chk("t2_len", 32'(lastLen), 32'd3);
    chk("t2_we", 32'(lastWe), 32'd0);
    chk("t2_addr", 32'(lastAddr), 32'h10);
    chk("t2_pulses", 32'(doneCount - dc0), 32'd1);

    // 3: read beats write, then write alone
    drive(0, 0, 1, 1, 32'hA5A5_A5A5);
    drive(0, 0, 1, 0, 32'h0000_01FF);
    ackAfter = 1; rdataNext = 32'hA5A5_A5A5;
    drive(1, 1, 0, 0, 32'h0);
    waitDone("t3_rd_wait");
    chk("t3_rd_we", 32'(lastWe), 32'd0);
    chk("t3_rd_addr", 32'(lastAddr), 32'h1FF);
    Write = 1'b1;
    @(negedge clock);
    Write = 1'b0;

    // 4: loads and starts during REQ are ignored (same write continues)
    ackAfter = 4;
    drive(1, 1, 1, 1, 32'hFFFF_FFFF);
    drive(0, 1, 0, 0, 32'h0);
    waitDone("t4_done_wait");
    chk("t3_wr_we", 32'(lastWe), 32'd1);
    chk("t3_wr_wdata", lastWdata, 32'hA5A5_A5A5);
    rc0 = reqCount;
    repeat (4) @(negedge clock);
    chk("t4_mdr", mdr_out, 32'hA5A5_A5A5);
    chk("t4_mar", 32'(mar_out), 32'h1FF);
    chk("t4_noextra", 32'(reqCount - rc0), 32'd0);

    // 5: reset in the middle of a request, then stray acks
    ackAfter = 0;
    drive(1, 0, 0, 0, 32'h0);
    @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    chk("t5_req", 32'(mem_req), 32'd0);
    chk("t5_mar", 32'(mar_out), 32'd0);
    chk("t5_mdr", mdr_out, 32'd0);
    forceAck = 1'b1;
    repeat (3) @(negedge clock);
    forceAck = 1'b0;
    @(negedge clock);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_mdr2", mdr_out, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // 6: timeout abort leaves MDR, sets err; next start clears err
    drive(0, 0, 0, 1, 32'h0BAD_0BAD);
    ackAfter = 0;
    drive(1, 0, 0, 0, 32'h0);
    waitDone("t6_done_wait");
    @(negedge clock);
    chk("t6_len", 32'(lastLen), 32'(TO));
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_mdr", mdr_out, 32'h0BAD_0BAD);
    ackAfter = 2;
    drive(1, 0, 0, 0, 32'h0);
    chk("t6_errclr", 32'(err), 32'd0);
    waitDone("t6b_done_wait");
`endif

    // randomized traffic
    randMode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      clear_n = ($urandom_range(0, 149) != 0);
      Read    = ($urandom_range(0, 5) == 0);
      Write   = ($urandom_range(0, 5) == 0);
      MARin   = ($urandom_range(0, 2) == 0);
      MDRin   = ($urandom_range(0, 2) == 0);
      bus_in  = $urandom;
      @(negedge clock);
    end
    clear_n = 1'b1; Read = 1'b0; Write = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    repeat (20) @(negedge clock);
    chk("end_reqQ", 32'(reqQ.size()), 32'd0);
    chk("end_doneQ", 32'(doneQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
